// File: rtl/dm_sync_param.sv
// dm_sync_param: word-organised data memory for the RV32I cores.
// There is one read/write port, and the read data is registered.
// Requests use a valid/ready handshake and get a one-cycle response pulse.
// An access that crosses a word boundary is split into two beats on the same port.

module dm_sync_param #(
  parameter int ADDR_BITS        = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter bit INIT_ZERO        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int WORDS    = 2 ** IDX_BITS;
  localparam logic [ADDR_BITS:0] CAPACITY  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [31:0]        INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t state;
  state_t state_next;

  // Storage: one array of 32-bit words with a write enable per byte lane.
  logic [31:0] mem [WORDS] = '{default: INIT_WORD};

  // Request decode
  logic [1:0]         off;
  logic [2:0]         nbytes;
  logic [ADDR_BITS:0] nb_ext;
  logic [ADDR_BITS:0] end_addr;
  logic               legal;
  logic               out_range;
  logic               misalign;
  logic               split;
  logic               req_err;
  logic               accept;
  logic [7:0]         be_base;
  logic [7:0]         wide_be;
  logic [63:0]        wide_data;

  // Memory port
  logic                port_en;
  logic [IDX_BITS-1:0] port_idx;
  logic [3:0]          port_be;
  logic [31:0]         port_wdata;
  logic [31:0]         port_rdata;

  // State for the second beat and the pending response
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic                resp_load;
  logic                resp_split;
  logic [2:0]          resp_ctrl;
  logic [1:0]          resp_off;
  logic [IDX_BITS-1:0] hi_idx;
  logic [3:0]          hi_be;
  logic [31:0]         hi_wdata;
  logic [31:0]         lo_save;

  // Response formatting
  logic [63:0] wide_rd;
  logic [31:0] aligned;

  assign accept = req_valid && req_ready;

  // Decode the request: size, legality, range, and whether it crosses a word boundary.
  always_comb begin
    off    = req_addr[1:0];
    nbytes = 3'd1;
    case (req_ctrl[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    if (req_we) begin
      legal = !req_ctrl[2] && (req_ctrl[1:0] != 2'b11);
    end else begin
      legal = (req_ctrl[1:0] != 2'b11) && !(req_ctrl[2] && req_ctrl[1]);
    end
    nb_ext      = '0;
    nb_ext[2:0] = nbytes;
    end_addr    = {1'b0, req_addr[ADDR_BITS-1:0]} + nb_ext;
    out_range   = (|req_addr[31:ADDR_BITS]) || (end_addr > CAPACITY);
    misalign    = ((nbytes == 3'd2) && off[0]) || ((nbytes == 3'd4) && (off != 2'b00));
    split       = (({1'b0, off} + nbytes) > 3'd4);
    req_err     = !legal || out_range || (misalign && !ALLOW_MISALIGNED);
    be_base     = 8'b0000_0001;
    case (nbytes)
      3'd2:    be_base = 8'b0000_0011;
      3'd4:    be_base = 8'b0000_1111;
      default: be_base = 8'b0000_0001;
    endcase
    wide_be   = be_base << off;
    wide_data = {32'b0, req_wdata} << {off, 3'b000};
  end

  // Steer the single port: the accepted request's low word, or the saved second beat.
  always_comb begin
    port_en    = 1'b0;
    port_idx   = req_addr[ADDR_BITS-1:2];
    port_be    = 4'b0000;
    port_wdata = wide_data[31:0];
    if (state == S_SPLIT) begin
      port_en    = 1'b1;
      port_idx   = hi_idx;
      port_be    = hi_be;
      port_wdata = hi_wdata;
    end else if (accept && !req_err) begin
      port_en = 1'b1;
      if (req_we) begin
        port_be = wide_be[3:0];
      end
    end
  end

  // Byte-enabled write and registered read. This process has no reset, so the contents survive reset.
  always_ff @(posedge clk) begin
    if (port_en) begin
      for (int k = 0; k < 4; k++) begin
        if (port_be[k]) begin
          mem[port_idx][8*k +: 8] <= port_wdata[8*k +: 8];
        end
      end
      port_rdata <= mem[port_idx];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: only a legal word-crossing access takes the extra beat.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && !req_err && split) state_next = S_SPLIT;
      S_SPLIT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: stall new requests while the second beat uses the port.
  always_comb begin
    req_ready = (state == S_IDLE);
  end

  // Capture the response attributes and the second-beat data.
  // Raise the response pulse when the last beat completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      resp_load   <= 1'b0;
      resp_split  <= 1'b0;
      resp_ctrl   <= 3'b000;
      resp_off    <= 2'b00;
      hi_idx      <= '0;
      hi_be       <= 4'b0000;
      hi_wdata    <= 32'h0;
      lo_save     <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (state == S_SPLIT) begin
        rsp_valid_q <= 1'b1;
        lo_save     <= port_rdata;
      end else if (accept) begin
        resp_ctrl  <= req_ctrl;
        resp_off   <= off;
        resp_load  <= !req_we && !req_err;
        resp_split <= split && !req_err;
        hi_idx     <= req_addr[ADDR_BITS-1:2] + 1'b1;
        hi_be      <= req_we ? wide_be[7:4] : 4'b0000;
        hi_wdata   <= wide_data[63:32];
        if (req_err) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end else if (!split) begin
          rsp_valid_q <= 1'b1;
        end
      end
    end
  end

  // Merge the beats little-endian, shift the addressed bytes down, then sign- or zero-extend.
  always_comb begin
    wide_rd = resp_split ? {port_rdata, lo_save} : {32'b0, port_rdata};
    aligned = 32'(wide_rd >> {resp_off, 3'b000});
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = 32'h0;
    if (rsp_valid_q && resp_load) begin
      case (resp_ctrl[1:0])
        2'b00:   rsp_rdata = {{24{~resp_ctrl[2] & aligned[7]}}, aligned[7:0]};
        2'b01:   rsp_rdata = {{16{~resp_ctrl[2] & aligned[15]}}, aligned[15:0]};
        default: rsp_rdata = aligned;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_sync_param.sv
// tb_dm_sync_param: vector table, hand-written corner sequences and random
// requests checked against a byte-array model of the memory.

module tb_dm_sync_param;

  localparam int ADDR_BITS = 10;
  localparam bit ALLOW     = 1'b1;
  localparam int MEM_BYTES = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [MEM_BYTES];

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [26];

  dm_sync_param #(
    .ADDR_BITS(ADDR_BITS),
    .ALLOW_MISALIGNED(ALLOW),
    .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_ctrl(req_ctrl),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: end of test not reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: the byte-addressed memory. The request is evaluated from the access rules directly.
  task automatic modelReq(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic exp_err,
                          output logic [31:0] exp_rdata, output int exp_lat);
    int          n;
    bit          legal;
    longint      last;
    logic [31:0] v;
    case (ctrl[1:0])
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 1;
    endcase
    legal     = we ? (ctrl inside {3'd0, 3'd1, 3'd2}) : (ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    last      = longint'(addr) + longint'(n) - 1;
    exp_err   = !legal || (last >= longint'(MEM_BYTES)) || (!ALLOW && ((addr % n) != 0));
    exp_rdata = 32'h0;
    exp_lat   = 1;
    if (!exp_err) begin
      if (int'(addr % 4) + n > 4) exp_lat = 2;
      if (we) begin
        for (int k = 0; k < n; k++) model_mem[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(model_mem[int'(addr) + k]) << (8 * k));
        if (!ctrl[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_rdata = v;
      end
    end
  endtask

  // Issue one request when the block is idle, and check the stall and the response at the expected latency.
  task automatic applyStimulus(input string name, input logic we, input logic [2:0] ctrl,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    checkOutput({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (exp_lat == 2) begin
      checkOutput({name, " split stall"}, 32'(req_ready), 32'd0);
      checkOutput({name, " no early rsp"}, 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    checkOutput({name, " rdata"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    int          l;
    logic [31:0] d;
    logic        rw;
    logic [2:0]  rc;
    logic [31:0] ra;
    int          sel;
    logic [31:0] b2b_exp [4];

    // Hold reset for a few cycles, then check the idle outputs.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill the whole memory with random words so the model knows every byte.
    for (int w = 0; w < MEM_BYTES / 4; w++) begin
      d = $urandom;
      modelReq(1'b1, 3'd2, 32'(w * 4), d, e, r, l);
      applyStimulus("fill", 1'b1, 3'd2, 32'(w * 4), d, e, r, l);
    end

    // Directed vectors: name, we, ctrl, addr, wdata, err, rdata, latency
    tbl[0]  = '{"sw_dead",      1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 1};
    tbl[1]  = '{"lw_10",        1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 1};
    tbl[2]  = '{"lb_13",        1'b0, 3'd0, 32'h013, 32'h0,        1'b0, 32'hFFFFFFDE, 1};
    tbl[3]  = '{"lbu_13",       1'b0, 3'd4, 32'h013, 32'h0,        1'b0, 32'h000000DE, 1};
    tbl[4]  = '{"lh_12",        1'b0, 3'd1, 32'h012, 32'h0,        1'b0, 32'hFFFFDEAD, 1};
    tbl[5]  = '{"lhu_12",       1'b0, 3'd5, 32'h012, 32'h0,        1'b0, 32'h0000DEAD, 1};
    tbl[6]  = '{"sw_0c",        1'b1, 3'd2, 32'h00C, 32'hCAFEF00D, 1'b0, 32'h00000000, 1};
    tbl[7]  = '{"sw_split_0e",  1'b1, 3'd2, 32'h00E, 32'h11223344, 1'b0, 32'h00000000, 2};
    tbl[8]  = '{"lw_0c",        1'b0, 3'd2, 32'h00C, 32'h0,        1'b0, 32'h3344F00D, 1};
    tbl[9]  = '{"lw_10b",       1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hDEAD1122, 1};
    tbl[10] = '{"lw_split_0e",  1'b0, 3'd2, 32'h00E, 32'h0,        1'b0, 32'h11223344, 2};
    tbl[11] = '{"lh_split_0f",  1'b0, 3'd1, 32'h00F, 32'h0,        1'b0, 32'h00002233, 2};
    tbl[12] = '{"sb_3ff",       1'b1, 3'd0, 32'h3FF, 32'h1234565A, 1'b0, 32'h00000000, 1};
    tbl[13] = '{"sh_3ff_err",   1'b1, 3'd1, 32'h3FF, 32'h0000BBCC, 1'b1, 32'h00000000, 1};
    tbl[14] = '{"lbu_3ff",      1'b0, 3'd4, 32'h3FF, 32'h0,        1'b0, 32'h0000005A, 1};
    tbl[15] = '{"lw_400_err",   1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h00000000, 1};
    tbl[16] = '{"lw_3fd_err",   1'b0, 3'd2, 32'h3FD, 32'h0,        1'b1, 32'h00000000, 1};
    tbl[17] = '{"lb_3ff",       1'b0, 3'd0, 32'h3FF, 32'h0,        1'b0, 32'h0000005A, 1};
    tbl[18] = '{"sw_20",        1'b1, 3'd2, 32'h020, 32'h01020304, 1'b0, 32'h00000000, 1};
    tbl[19] = '{"ld_ctrl3_err", 1'b0, 3'd3, 32'h020, 32'h0,        1'b1, 32'h00000000, 1};
    tbl[20] = '{"st_ctrl4_err", 1'b1, 3'd4, 32'h020, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1};
    tbl[21] = '{"lw_20",        1'b0, 3'd2, 32'h020, 32'h0,        1'b0, 32'h01020304, 1};
    tbl[22] = '{"ld_ctrl7_err", 1'b0, 3'd7, 32'h020, 32'h0,        1'b1, 32'h00000000, 1};
    tbl[23] = '{"lw_high_err",  1'b0, 3'd2, 32'h80000010, 32'h0,   1'b1, 32'h00000000, 1};
    tbl[24] = '{"sb_21",        1'b1, 3'd0, 32'h021, 32'h000000AB, 1'b0, 32'h00000000, 1};
    tbl[25] = '{"lb_21",        1'b0, 3'd0, 32'h021, 32'h0,        1'b0, 32'hFFFFFFAB, 1};

    for (int i = 0; i < 26; i++) begin
      modelReq(tbl[i].we, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata, e, r, l);
      applyStimulus(tbl[i].name, tbl[i].we, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata,
                    tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat);
    end

    // Four back-to-back word loads: one response per cycle, ready never drops.
    for (int i = 0; i < 4; i++) modelReq(1'b0, 3'd2, 32'(4 * i), 32'h0, e, b2b_exp[i], l);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_ctrl  = 3'd2;
      req_addr  = 32'(4 * i);
      @(posedge clk);
      #1;
      checkOutput("b2b ready", 32'(req_ready), 32'd1);
      checkOutput("b2b rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("b2b rdata", rsp_rdata, b2b_exp[i]);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b pulse ends", 32'(rsp_valid), 32'd0);

    // Reset during the SPLIT cycle of a misaligned store: only the first-beat bytes land.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_ctrl  = 3'd2;
    req_addr  = 32'h01E;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    checkOutput("rst split stall", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst split ready", 32'(req_ready), 32'd1);
    checkOutput("rst split no rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after rst no rsp", 32'(rsp_valid), 32'd0);
    checkOutput("after rst ready", 32'(req_ready), 32'd1);
    model_mem[32'h01E] = 8'hDD;
    model_mem[32'h01F] = 8'hCC;
    modelReq(1'b0, 3'd2, 32'h01C, 32'h0, e, r, l);
    applyStimulus("rst first word", 1'b0, 3'd2, 32'h01C, 32'h0, e, r, l);
    modelReq(1'b0, 3'd2, 32'h020, 32'h0, e, r, l);
    checkOutput("rst second word model", r, 32'h0102AB04);
    applyStimulus("rst second word", 1'b0, 3'd2, 32'h020, 32'h0, e, r, l);

    // Random requests against the model, with occasional idle cycles.
    for (int i = 0; i < 400; i++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      rc  = (sel < 8) ? 3'(sel) : 3'd2;
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = 32'h400 + 32'($urandom_range(0, 8));
      else if (sel == 1) ra = 32'h3F8 + 32'($urandom_range(0, 7));
      else if (sel == 2) ra = $urandom;
      else               ra = 32'($urandom_range(0, MEM_BYTES - 1));
      d = $urandom;
      modelReq(rw, rc, ra, d, e, r, l);
      applyStimulus("rand", rw, rc, ra, d, e, r, l);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        checkOutput("rand idle no rsp", 32'(rsp_valid), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
